// File: rtl/reaction_timer_fsm.sv
// reaction_timer_fsm: control and measurement stage of the reaction-timer stopwatch.
// Waits a pseudo-random interval after a start press, lights the GO LED, then
// counts 1 kHz ticks as a 4-digit BCD millisecond value until react is pressed.
// False starts (react during the wait) and time-outs (9.999 s) are flagged.
//
// Optional feature: define RT_BEST_TIME_EN to build the best-time register;
// otherwise best_bcd is the constant 16'h9999.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   tick         1-clk pulse at 1 kHz
//   start        debounced start button (level)
//   react        debounced reaction button (level)
//   rand_val     LFSR value, sampled on the start edge only
//   state        IDLE=00, WAIT=01, RUN=10, DONE=11
//   led_go       high only in RUN
//   time_bcd     measured time {sec, 100ms, 10ms, 1ms} in BCD
//   false_start  react pressed during WAIT
//   timeout      RUN reached 9.999 s without react
//   best_bcd     best valid time since reset
module reaction_timer_fsm #(
    parameter int unsigned BASE_DELAY_MS = 1000,
    parameter int unsigned RAND_SCALE    = 16,
    parameter int unsigned DLY_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        react,
    input  logic [6:0]  rand_val,
    output logic [1:0]  state,
    output logic        led_go,
    output logic [15:0] time_bcd,
    output logic        false_start,
    output logic        timeout,
    output logic [15:0] best_bcd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             state_q;
    logic               start_q;
    logic               react_q;
    logic [DLY_W-1:0]   dly;

    logic               start_edge_c;
    logic               react_edge_c;
    logic [DLY_W-1:0]   dly_load_c;

    // Button history resets to 1 so a button held through reset does not fire.
    assign start_edge_c = start & ~start_q;
    assign react_edge_c = react & ~react_q;

    assign dly_load_c = DLY_W'(BASE_DELAY_MS) + DLY_W'(rand_val) * DLY_W'(RAND_SCALE);

    assign state = state_q;

    // Four-digit BCD increment with ripple carry; caller handles 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifndef RT_BEST_TIME_EN
    assign best_bcd = 16'h9999;
`endif

    // Round control FSM; react edges take precedence over a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            led_go      <= 1'b0;
            time_bcd    <= 16'h0000;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            dly         <= '0;
            start_q     <= 1'b1;
            react_q     <= 1'b1;
`ifdef RT_BEST_TIME_EN
            best_bcd    <= 16'h9999;
`endif
        end else begin
            start_q <= start;
            react_q <= react;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge_c) begin
                        dly         <= dly_load_c;
                        time_bcd    <= 16'h0000;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (react_edge_c) begin
                        false_start <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (tick) begin
                        // A load of 0 or 1 still spends one tick in WAIT.
                        if (dly <= DLY_W'(1)) begin
                            dly     <= '0;
                            led_go  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            dly <= dly - DLY_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (react_edge_c) begin
                        led_go  <= 1'b0;
                        state_q <= S_DONE;
`ifdef RT_BEST_TIME_EN
                        // Unsigned compare orders BCD values correctly.
                        if (time_bcd < best_bcd) begin
                            best_bcd <= time_bcd;
                        end
`endif
                    end else if (tick) begin
                        if (time_bcd == 16'h9999) begin
                            led_go  <= 1'b0;
                            timeout <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            time_bcd <= bcd_inc(time_bcd);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Self-checking bench for reaction_timer_fsm with randomized tick/button
// stimulus. Expected values come from tick counts kept by the bench.
module tb_reaction_timer_fsm;

    localparam int unsigned BASE = 5;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam int M_REACT   = 0;
    localparam int M_FALSE   = 1;
    localparam int M_TIMEOUT = 2;
    localparam int M_REACT_T = 3;
    localparam int M_RESET   = 4;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        start;
    logic        react;
    logic [6:0]  rand_val;
    logic [1:0]  state;
    logic        led_go;
    logic [15:0] time_bcd;
    logic        false_start;
    logic        timeout;
    logic [15:0] best_bcd;

    int vectors;
    int miscompares;

    // Expected observable state
    logic [1:0]  e_state;
    logic        e_led;
    logic [15:0] e_time;
    logic        e_fs;
    logic        e_to;
    int          best_cnt;

    reaction_timer_fsm #(
        .BASE_DELAY_MS (BASE),
        .RAND_SCALE    (1),
        .DLY_W         (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .react       (react),
        .rand_val    (rand_val),
        .state       (state),
        .led_go      (led_go),
        .time_bcd    (time_bcd),
        .false_start (false_start),
        .timeout     (timeout),
        .best_bcd    (best_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_best;
`ifdef RT_BEST_TIME_EN
        e_best = to_bcd(best_cnt);
`else
        e_best = 16'h9999;
`endif
        check_val({tag, ".state"},       16'(state),       16'(e_state));
        check_val({tag, ".led_go"},      16'(led_go),      16'(e_led));
        check_val({tag, ".time_bcd"},    time_bcd,         e_time);
        check_val({tag, ".false_start"}, 16'(false_start), 16'(e_fs));
        check_val({tag, ".timeout"},     16'(timeout),     16'(e_to));
        check_val({tag, ".best_bcd"},    best_bcd,         e_best);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        e_state  = ST_IDLE;
        e_led    = 1'b0;
        e_time   = 16'h0000;
        e_fs     = 1'b0;
        e_to     = 1'b0;
        best_cnt = 9999;
    endtask

    // One game round: start edge, random wait, measured run, and a short DONE hold.
    task automatic round(input int r, input int n, input int mode);
        int w;
        int k;
        int t;
        int fs_at;
        int target;

        start = 1'b0; react = 1'b0; tick = 1'($urandom % 2);
        step();
        check_all("pre_start");

        rand_val = 7'(r); start = 1'b1; tick = 1'($urandom % 2);
        step();
        e_state = ST_WAIT; e_time = 16'h0000; e_fs = 1'b0; e_to = 1'b0; e_led = 1'b0;
        check_all("load");

        w     = (BASE + r < 1) ? 1 : BASE + r;
        fs_at = (mode == M_FALSE) ? $urandom_range(w - 1, 0) : w;
        k     = 0;
        while (k < w) begin
            rand_val = 7'($urandom);
            start    = 1'($urandom % 2);
            if (k == fs_at) begin
                react = 1'b1; tick = 1'($urandom % 2);
                step();
                e_state = ST_DONE; e_fs = 1'b1;
                check_all("false_start");
                break;
            end
            react = 1'b0; tick = 1'($urandom % 2);
            step();
            if (tick) k++;
            if (k == w) begin
                e_state = ST_RUN; e_led = 1'b1;
            end
            check_all("wait");
        end

        if (mode != M_FALSE) begin
            target = (mode == M_TIMEOUT) ? 9999 : n;
            t = 0;
            while (t < target) begin
                start = 1'($urandom % 2); react = 1'b0; tick = 1'($urandom % 2);
                step();
                if (tick) t++;
                e_time = to_bcd(t);
                check_all("run");
            end

            if (mode == M_RESET) begin
                reset = 1'b1;
                #2;
                model_reset();
                check_all("mid_reset");
                start = 1'b0; react = 1'b0;
                step();
                reset = 1'b0;
                step();
                check_all("post_reset");
                return;
            end else if (mode == M_TIMEOUT) begin
                tick = 1'b1;
                step();
                e_state = ST_DONE; e_led = 1'b0; e_to = 1'b1;
                check_all("timeout");
            end else begin
                react = 1'b1;
                tick  = (mode == M_REACT_T) ? 1'b1 : 1'($urandom % 2);
                step();
                e_state = ST_DONE; e_led = 1'b0;
                if (t < best_cnt) best_cnt = t;
                check_all("react");
            end
        end

        // DONE ignores react and holds the result
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            react = 1'($urandom % 2); tick = 1'($urandom % 2);
            step();
            check_all("done_hold");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        vectors     = 0;
        miscompares = 0;
        model_reset();

        reset = 1'b1; start = 1'b1; react = 1'b1; tick = 1'b0; rand_val = 7'd0;
        repeat (3) step();
        check_all("reset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'($urandom % 2);
            step();
            check_all("held_start");
        end

        round(3,  1234, M_REACT);
        round(40, 2000, M_REACT);
        round(10, 0,    M_FALSE);
        round(0,  0,    M_TIMEOUT);
        round(7,  41,   M_REACT_T);
        round(0,  0,    M_REACT);
        for (int i = 0; i < 8; i++) begin
            m = $urandom_range(2, 0);
            if (m == M_TIMEOUT) m = M_REACT_T;
            round(int'($urandom % 128), $urandom_range(300, 1), m);
        end
        round(20, 100, M_RESET);
        round(5,  50,  M_REACT);
        round(127, 3,  M_REACT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
